// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage: instruction field positions,
// control bundle, the default-width ID/EX bundle layout and the interlock FSM states.
package decode_pkg;

    localparam int unsigned DEF_DATA_W    = 24;
    localparam int unsigned DEF_REG_IDX_W = 4;
    localparam int unsigned DEF_IMM_W     = 18;
    localparam int unsigned DEF_PC_W      = 32;

    // Instruction word layout (LSB position of each field)
    localparam int unsigned OP_TYPE_LSB = 30;
    localparam int unsigned OP_CODE_LSB = 26;
    localparam int unsigned RC_LSB      = 22;
    localparam int unsigned RA_LSB      = 18;
    localparam int unsigned RB_LSB      = 14;

    // Opcode classes understood by controlUnit
    localparam logic [1:0] OP_ALU  = 2'b00;
    localparam logic [1:0] OP_ALUI = 2'b01;
    localparam logic [1:0] OP_MEM  = 2'b10;
    localparam logic [1:0] OP_BR   = 2'b11;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_e;

    typedef struct packed {
        logic       imm_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    // Bundle layout at default widths, MSB first
    typedef struct packed {
        logic [DEF_PC_W-1:0]      pc;
        logic [1:0]               op_type;
        logic [3:0]               op_code;
        ctrl_t                    ctrl;
        logic [DEF_REG_IDX_W-1:0] ra;
        logic [DEF_DATA_W-1:0]    rd1;
        logic [DEF_REG_IDX_W-1:0] rb;
        logic [DEF_DATA_W-1:0]    rd2;
        logic [DEF_REG_IDX_W-1:0] rc;
        logic [DEF_DATA_W-1:0]    rd3;
        logic [DEF_DATA_W-1:0]    imm_ext;
    } id_ex_t;

endpackage

// File: rtl/controlUnit.sv
// Main control decoder shared across the pipeline: maps op_type/op_code to control bits.
module controlUnit (
    input  logic [1:0] op_type,
    input  logic [3:0] op_code,
    output logic       imm_src,
    output logic       branch,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [3:0] alu_ctrl
);

    // Decode class; memory ops use op_code[0] to pick store (1) or load (0)
    always_comb begin
        imm_src    = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_ctrl   = 4'h0;
        case (op_type)
            2'b00: begin
                reg_write = 1'b1;
                alu_ctrl  = op_code;
            end
            2'b01: begin
                reg_write = 1'b1;
                imm_src   = 1'b1;
                alu_ctrl  = op_code;
            end
            2'b10: begin
                imm_src = 1'b1;
                if (op_code[0]) begin
                    mem_write = 1'b1;
                end else begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
            end
            default: begin
                branch   = 1'b1;
                imm_src  = 1'b1;
                alu_ctrl = 4'h1;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_wf.sv
// Three-read / one-write register file with write-first bypass and synchronous clear.
module reg_file_wf #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    input  logic [REG_IDX_W-1:0] raddr_c,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b,
    output logic [DATA_W-1:0]    rdata_c
);

    localparam int unsigned NumRegs = 2 ** REG_IDX_W;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] regs_d [NumRegs];

    // Next register contents; reads come from here so a same-cycle write is bypassed
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_d[raddr_a];
    assign rdata_b = regs_d[raddr_b];
    assign rdata_c = regs_d[raddr_c];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits the instruction, reads the register file, decodes control and
// registers a packed ID/EX bundle behind valid/ready handshakes with branch flush.
// Define DECODE_HAZARD_EN to compile in the load-use interlock (LU_BUBBLES bubbles).
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned REG_IDX_W  = 4,
    parameter int unsigned IMM_W      = 18,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned LU_BUBBLES = 1,
    localparam int unsigned BUNDLE_W  = PC_W + 6 + $bits(ctrl_t) + 3 * (REG_IDX_W + DATA_W)
                                        + DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst,
    input  logic [PC_W-1:0]      pc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_wd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUNDLE_W-1:0]  out_bundle
);

    logic [1:0]           op_type;
    logic [3:0]           op_code;
    logic [REG_IDX_W-1:0] ra, rb, rc;
    logic [IMM_W-1:0]     imm;
    logic [DATA_W-1:0]    rd1, rd2, rd3, imm_ext;
    logic                 cu_imm_src, cu_branch, cu_mem_write, cu_mem_to_reg, cu_reg_write;
    logic [3:0]           cu_alu_ctrl;
    ctrl_t                ctrl;
    logic                 hazard, run, fire_in, fire_out;
    logic                 out_valid_q, out_valid_d;
    logic [BUNDLE_W-1:0]  out_bundle_q, out_bundle_d, new_bundle;

    assign op_type = inst[OP_TYPE_LSB +: 2];
    assign op_code = inst[OP_CODE_LSB +: 4];
    assign rc      = inst[RC_LSB +: REG_IDX_W];
    assign ra      = inst[RA_LSB +: REG_IDX_W];
    assign rb      = inst[RB_LSB +: REG_IDX_W];
    assign imm     = inst[IMM_W-1:0];
    assign imm_ext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};

    reg_file_wf #(
        .DATA_W    (DATA_W),
        .REG_IDX_W (REG_IDX_W)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_wd),
        .raddr_a (ra),
        .raddr_b (rb),
        .raddr_c (rc),
        .rdata_a (rd1),
        .rdata_b (rd2),
        .rdata_c (rd3)
    );

    controlUnit u_ctrl (
        .op_type    (op_type),
        .op_code    (op_code),
        .imm_src    (cu_imm_src),
        .branch     (cu_branch),
        .mem_write  (cu_mem_write),
        .mem_to_reg (cu_mem_to_reg),
        .reg_write  (cu_reg_write),
        .alu_ctrl   (cu_alu_ctrl)
    );

    assign ctrl = {cu_imm_src, cu_branch, cu_mem_write, cu_mem_to_reg, cu_reg_write, cu_alu_ctrl};

    assign new_bundle = {pc, op_type, op_code, ctrl, ra, rd1, rb, rd2, rc, rd3, imm_ext};

    // Flush always accepts so the offered instruction is swallowed in the same cycle
    assign in_ready = rst || flush || (run && !hazard && (!out_valid_q || out_ready));
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid_q && out_ready;

`ifdef DECODE_HAZARD_EN
    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 hz_load_q, hz_load_d;
    logic [REG_IDX_W-1:0] hz_rc_q, hz_rc_d;

    assign run    = (state_q == RUN);
    assign hazard = in_valid && out_valid_q && hz_load_q &&
                    ((hz_rc_q == ra) || (hz_rc_q == rb) || (ctrl.mem_write && (hz_rc_q == rc)));

    // Track the held instruction's load/destination and count extra bubbles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hz_load_d = hz_load_q;
        hz_rc_d   = hz_rc_q;
        if (fire_in && !flush) begin
            hz_load_d = ctrl.mem_to_reg && ctrl.reg_write;
            hz_rc_d   = rc;
        end
        if (flush) begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end else if (state_q == BUBBLE) begin
            if (cnt_q == 2'd1) begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end else if (hazard && fire_out && (LU_BUBBLES > 1)) begin
            state_d = BUBBLE;
            cnt_d   = 2'(LU_BUBBLES - 1);
        end
    end

    // Interlock state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 2'd0;
            hz_load_q <= 1'b0;
            hz_rc_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hz_load_q <= hz_load_d;
            hz_rc_q   <= hz_rc_d;
        end
    end
`else
    logic unused_lu;

    assign run       = 1'b1;
    assign hazard    = 1'b0;
    assign unused_lu = |LU_BUBBLES;
`endif

    // Output register: flush kills, accept loads, drain without accept empties
    always_comb begin
        out_valid_d  = out_valid_q;
        out_bundle_d = out_bundle_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire_in) begin
            out_valid_d  = 1'b1;
            out_bundle_d = new_bundle;
        end else if (fire_out) begin
            out_valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_bundle_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_bundle_q <= out_bundle_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bundle = out_bundle_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage with a behavioural scoreboard model.
module tb_decode_stage;

    localparam int unsigned LU = 2;
    localparam int unsigned BW = 155;

`ifdef DECODE_HAZARD_EN
    localparam bit HZ      = 1'b1;
    localparam int EXP_BUB = LU;
`else
    localparam bit HZ      = 1'b0;
    localparam int EXP_BUB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, flush, wb_we, out_ready;
    logic [31:0]   inst, pc;
    logic [3:0]    wb_rd;
    logic [23:0]   wb_wd;
    logic          in_ready, out_valid;
    logic [BW-1:0] out_bundle;

    int            errors = 0;
    int            checks = 0;

    // Model state
    logic          m_valid;
    logic [BW-1:0] m_bundle;
    logic [23:0]   regs_m [16];
    logic          exp_rdy, obs_rdy;

    decode_stage #(
        .LU_BUBBLES (LU)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .pc         (pc),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_wd      (wb_wd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bundle (out_bundle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] c,
                                       input logic [3:0] rc, input logic [3:0] ra,
                                       input logic [17:0] im);
        return {t, c, rc, ra, im};
    endfunction

    // Control bits {imm_src, branch, mem_write, mem_to_reg, reg_write, alu_ctrl}
    function automatic logic [8:0] ctrl_of(input logic [1:0] t, input logic [3:0] c);
        case (t)
            2'b00:   return {5'b00001, c};
            2'b01:   return {5'b10001, c};
            2'b10:   return c[0] ? {5'b10100, 4'h0} : {5'b10011, 4'h0};
            default: return {5'b11000, 4'h1};
        endcase
    endfunction

    function automatic logic [23:0] rd_m(input logic [3:0] idx, input logic we,
                                         input logic [3:0] wr, input logic [23:0] wd);
        return (we && wr == idx) ? wd : regs_m[idx];
    endfunction

    function automatic logic [BW-1:0] exp_bundle(input logic [31:0] ins, input logic [31:0] p,
                                                 input logic we, input logic [3:0] wr,
                                                 input logic [23:0] wd);
        logic [3:0]  a, b, c;
        logic [23:0] ie;
        c  = ins[25:22];
        a  = ins[21:18];
        b  = ins[17:14];
        ie = 24'($signed(ins[17:0]));
        return {p, ins[31:30], ins[29:26], ctrl_of(ins[31:30], ins[29:26]),
                a, rd_m(a, we, wr, wd), b, rd_m(b, we, wr, wd), c, rd_m(c, we, wr, wd), ie};
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_bundle = '0;
        for (int i = 0; i < 16; i++) regs_m[i] = '0;
    endtask

    // Drives one cycle (entered and left at posedge+1) and advances the model
    task automatic drive_cycle(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                               input logic ordy, input logic fl, input logic we,
                               input logic [3:0] wr, input logic [23:0] wd);
        logic [BW-1:0] nb;
        in_valid  = iv;
        inst      = ins;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
        wb_we     = we;
        wb_rd     = wr;
        wb_wd     = wd;
        nb        = exp_bundle(ins, p, we, wr, wd);
        exp_rdy   = fl || !m_valid || ordy;
        #1;
        obs_rdy = in_ready;
        @(posedge clk);
        if (fl) m_valid = 1'b0;
        else if (iv && exp_rdy) begin
            m_valid  = 1'b1;
            m_bundle = nb;
        end else if (m_valid && ordy) m_valid = 1'b0;
        if (we) regs_m[wr] = wd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; inst = '0; pc = '0; flush = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_wd = '0; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset.in_ready got=%b want=1", in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        model_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset.out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (out_bundle !== '0) begin
            errors++; $display("FAIL reset.out_bundle got=%h want=0", out_bundle);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, mk(2'b00, 4'(i), 4'(i + 1), 4'd2, 18'h0C000 + 18'(i)),
                        32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
            checks++;
            if (obs_rdy !== 1'b1) begin
                errors++; $display("FAIL stream.in_ready[%0d] got=%b want=1", i, obs_rdy);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL stream.out_valid[%0d] got=%b want=1", i, out_valid);
            end
            checks++;
            if (out_bundle[BW-1 -: 32] !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL stream.pc[%0d] got=%h want=%h", i,
                                   out_bundle[BW-1 -: 32], 32'h100 + 32'(4 * i));
            end
            checks++;
            if (out_bundle !== m_bundle) begin
                errors++; $display("FAIL stream.bundle[%0d] got=%h want=%h", i, out_bundle,
                                   m_bundle);
            end
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream.drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] held;
        logic [31:0]   b_ins;
        b_ins = mk(2'b01, 4'h3, 4'd6, 4'd7, 18'h01234);
        drive_cycle(1'b1, mk(2'b00, 4'h2, 4'd1, 4'd2, 18'h08000), 32'h200, 1'b1, 1'b0,
                    1'b0, 4'd0, 24'd0);
        held = m_bundle;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, b_ins, 32'h204, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0);
            checks++;
            if (obs_rdy !== 1'b0) begin
                errors++; $display("FAIL bp.in_ready[%0d] got=%b want=0", i, obs_rdy);
            end
            checks++;
            if (out_valid !== 1'b1 || out_bundle !== held) begin
                errors++; $display("FAIL bp.hold[%0d] got=%b/%h want=1/%h", i, out_valid,
                                   out_bundle, held);
            end
        end
        drive_cycle(1'b1, b_ins, 32'h204, 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
        checks++;
        if (obs_rdy !== 1'b1 || out_valid !== 1'b1 || out_bundle[BW-1 -: 32] !== 32'h204) begin
            errors++; $display("FAIL bp.release got=%b/%b/%h want=1/1/204", obs_rdy, out_valid,
                               out_bundle[BW-1 -: 32]);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
    endtask

    task automatic test_bypass();
        drive_cycle(1'b1, mk(2'b00, 4'h0, 4'd1, 4'd5, 18'h08000), 32'h300, 1'b1, 1'b0,
                    1'b1, 4'd5, 24'hABCDEF);
        checks++;
        if (out_bundle[80 +: 24] !== 24'hABCDEF) begin
            errors++; $display("FAIL bypass.rd1 got=%h want=abcdef", out_bundle[80 +: 24]);
        end
        checks++;
        if (out_bundle !== m_bundle) begin
            errors++; $display("FAIL bypass.bundle got=%h want=%h", out_bundle, m_bundle);
        end
        drive_cycle(1'b1, mk(2'b00, 4'h0, 4'd0, 4'd5, 18'h00000), 32'h304, 1'b1, 1'b0,
                    1'b1, 4'd0, 24'h123456);
        checks++;
        if (out_bundle[80 +: 24] !== 24'hABCDEF || out_bundle[24 +: 24] !== 24'h123456) begin
            errors++; $display("FAIL bypass.r5_r0 got=%h/%h want=abcdef/123456",
                               out_bundle[80 +: 24], out_bundle[24 +: 24]);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
    endtask

    task automatic test_imm();
        drive_cycle(1'b1, mk(2'b01, 4'h0, 4'd0, 4'd0, 18'h20000), 32'h400, 1'b1, 1'b0,
                    1'b0, 4'd0, 24'd0);
        checks++;
        if (out_bundle[23:0] !== 24'hFE0000) begin
            errors++; $display("FAIL imm.neg got=%h want=fe0000", out_bundle[23:0]);
        end
        drive_cycle(1'b1, mk(2'b01, 4'h0, 4'd0, 4'd0, 18'h1FFFF), 32'h404, 1'b1, 1'b0,
                    1'b0, 4'd0, 24'd0);
        checks++;
        if (out_bundle[23:0] !== 24'h01FFFF) begin
            errors++; $display("FAIL imm.pos got=%h want=01ffff", out_bundle[23:0]);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, mk(2'b00, 4'h1, 4'd1, 4'd1, 18'h0), 32'h500, 1'b1, 1'b0, 1'b0,
                    4'd0, 24'd0);
        drive_cycle(1'b1, mk(2'b00, 4'h1, 4'd2, 4'd2, 18'h0), 32'h504, 1'b0, 1'b0, 1'b0,
                    4'd0, 24'd0);
        drive_cycle(1'b1, mk(2'b11, 4'h0, 4'd3, 4'd3, 18'h0), 32'h508, 1'b0, 1'b1, 1'b0,
                    4'd0, 24'd0);
        checks++;
        if (obs_rdy !== 1'b1) begin
            errors++; $display("FAIL flush.in_ready got=%b want=1", obs_rdy);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush.out_valid got=%b want=0", out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush.ghost[%0d] got=%b want=0", i, out_valid);
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0]   d_ins;
        logic [BW-1:0] nb;
        int            bubbles;
        bit            found;
        in_valid = 1'b1; inst = mk(2'b10, 4'h0, 4'd3, 4'd1, 18'h00010); pc = 32'h600;
        out_ready = 1'b1; flush = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_bundle[BW-1 -: 32] !== 32'h600) begin
            errors++; $display("FAIL lu.load got=%b/%h want=1/600", out_valid,
                               out_bundle[BW-1 -: 32]);
        end
        d_ins = mk(2'b00, 4'h0, 4'd4, 4'd3, 18'h08000);
        inst  = d_ins;
        pc    = 32'h604;
        nb    = exp_bundle(d_ins, 32'h604, 1'b0, 4'd0, 24'd0);
        #1;
        checks++;
        if (in_ready !== !HZ) begin
            errors++; $display("FAIL lu.in_ready got=%b want=%b", in_ready, !HZ);
        end
        bubbles = 0;
        found   = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk); #1;
            if (out_valid) found = 1'b1;
            else bubbles++;
        end
        in_valid = 1'b0;
        checks++;
        if (!found || out_bundle !== nb) begin
            errors++; $display("FAIL lu.dependent found=%b got=%h want=%h", found, out_bundle, nb);
        end
        checks++;
        if (bubbles !== EXP_BUB) begin
            errors++; $display("FAIL lu.bubbles got=%0d want=%0d", bubbles, EXP_BUB);
        end
        @(posedge clk); #1;
        m_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL lu.drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, mk(2'b00, 4'h0, 4'd1, 4'd5, 18'h0), 32'h700, 1'b1, 1'b0, 1'b0,
                    4'd0, 24'd0);
        drive_cycle(1'b1, mk(2'b00, 4'h0, 4'd2, 4'd5, 18'h0), 32'h704, 1'b0, 1'b0, 1'b0,
                    4'd0, 24'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid.in_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_bundle !== '0) begin
            errors++; $display("FAIL rstmid.out got=%b/%h want=0/0", out_valid, out_bundle);
        end
        drive_cycle(1'b1, mk(2'b00, 4'h0, 4'd2, 4'd5, 18'h0), 32'h704, 1'b1, 1'b0, 1'b0,
                    4'd0, 24'd0);
        checks++;
        if (out_valid !== 1'b1 || out_bundle[80 +: 24] !== 24'd0) begin
            errors++; $display("FAIL rstmid.reoffer got=%b/%h want=1/0", out_valid,
                               out_bundle[80 +: 24]);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 24'd0);
    endtask

    task automatic test_random();
        logic [1:0]  t;
        logic [3:0]  c;
        logic [31:0] ins;
        for (int i = 0; i < 300; i++) begin
            t = 2'($urandom_range(0, 2));
            c = 4'($urandom_range(0, 15));
            // Stores only in the memory class so no load-use hazard arises
            if (t == 2'b10) c[0] = 1'b1;
            ins = mk(t, c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     18'($urandom));
            drive_cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 15) == 0, 1'($urandom), 4'($urandom_range(0, 15)),
                        24'($urandom));
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand.in_ready[%0d] got=%b want=%b", i, obs_rdy, exp_rdy);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rand.out_valid[%0d] got=%b want=%b", i, out_valid,
                                   m_valid);
            end
            if (m_valid) begin
                checks++;
                if (out_bundle !== m_bundle) begin
                    errors++; $display("FAIL rand.bundle[%0d] got=%h want=%h", i, out_bundle,
                                       m_bundle);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bypass();
        test_imm();
        test_flush();
        test_load_use();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
